// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter giving N cores one access at a time to a shared word RAM, with ready timeout
//   CLK, CPU_Reset_n            clock, asynchronous active-low reset
//   CORE_ADDR/WDATA/WR/RR       per-core request, core i in slice i, held by the core until CORE_ACK
//   CORE_RDATA/ACK/ERR          read data, one-hot one-cycle completion pulse, timeout flag with ACK
//   MEM_ADDR/WDATA/WE/RE        registered shared RAM request, strobes held for the whole access
//   MEM_RDATA/READY             RAM read data and completion
//   BUSY                        arbiter not idle
module ram_arbiter #(
    parameter int Cores       = 2,
    parameter int AddrBits    = 16,
    parameter int DataBits    = 8,
    parameter int TimeoutBits = 8
) (
    input  logic                      CLK,
    input  logic                      CPU_Reset_n,
    input  logic [Cores*AddrBits-1:0] CORE_ADDR,
    input  logic [Cores*DataBits-1:0] CORE_WDATA,
    input  logic [Cores-1:0]          CORE_WR,
    input  logic [Cores-1:0]          CORE_RR,
    output logic [DataBits-1:0]       CORE_RDATA,
    output logic [Cores-1:0]          CORE_ACK,
    output logic [Cores-1:0]          CORE_ERR,
    output logic [AddrBits-1:0]       MEM_ADDR,
    output logic [DataBits-1:0]       MEM_WDATA,
    output logic                      MEM_WE,
    output logic                      MEM_RE,
    input  logic [DataBits-1:0]       MEM_RDATA,
    input  logic                      MEM_READY,
    output logic                      BUSY
);
    localparam int GW = (Cores > 1) ? $clog2(Cores) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t                 state, state_nx;
    logic [GW-1:0]          last_grant, grant, pick, idx;
    logic                   found, err, timeout;
    logic [Cores-1:0]       req, elig, rel, gmask;
    logic [TimeoutBits-1:0] cnt, cnt_inc;

    assign req     = CORE_WR | CORE_RR;
    // a core that keeps holding its request after ACK stays masked until it drops it
    assign elig    = req & ~rel;
    assign gmask   = Cores'(1) << grant;
    assign cnt_inc = cnt + 1'b1;
    // fires in the access cycle whose increment would reach all-ones
    assign timeout = &cnt_inc;

    assign CORE_ACK = (state == ACK) ? gmask : '0;
    assign CORE_ERR = CORE_ACK & {Cores{err}};
    assign BUSY     = state != IDLE;

    // descending scan so the first eligible core after last_grant is the one left in pick
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = Cores; k >= 1; k--) begin
            idx = GW'((int'(last_grant) + k) % Cores);
            if (elig[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        if (state == IDLE && found)
            state_nx = ACCESS;
        else if (state == ACCESS && (MEM_READY || timeout))
            state_nx = ACK;
        else if (state == ACK)
            state_nx = IDLE;
    end

    always_ff @(posedge CLK or negedge CPU_Reset_n) begin
        if (!CPU_Reset_n) begin
            state      <= IDLE;
            last_grant <= GW'(Cores - 1);
            grant      <= '0;
            rel        <= '0;
            cnt        <= '0;
            err        <= 1'b0;
            MEM_ADDR   <= '0;
            MEM_WDATA  <= '0;
            MEM_WE     <= 1'b0;
            MEM_RE     <= 1'b0;
            CORE_RDATA <= '0;
        end else begin
            state <= state_nx;
            // dropping the request clears the mask even in the ACK cycle itself
            rel   <= (rel | ((state == ACK) ? gmask : '0)) & req;
            cnt   <= (state == ACCESS) ? cnt_inc : '0;
            if (state == IDLE && found) begin
                grant     <= pick;
                MEM_ADDR  <= CORE_ADDR[pick*AddrBits +: AddrBits];
                MEM_WDATA <= CORE_WDATA[pick*DataBits +: DataBits];
                MEM_WE    <= CORE_WR[pick];
                MEM_RE    <= CORE_RR[pick] & ~CORE_WR[pick];
                err       <= 1'b0;
            end
            if (state == ACCESS && state_nx == ACK) begin
                MEM_WE <= 1'b0;
                MEM_RE <= 1'b0;
                err    <= !MEM_READY;
                if (!MEM_READY)
                    CORE_RDATA <= '0;
                else if (MEM_RE)
                    CORE_RDATA <= MEM_RDATA;
            end
            if (state == ACK)
                last_grant <= grant;
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized cores and RAM against a transaction-level arbiter model
module tb_ram_arbiter;
    localparam int C   = 3;
    localparam int AW  = 16;
    localparam int DW  = 8;
    localparam int TB  = 4;
    localparam int TMO = (1 << TB) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [C*AW-1:0] core_addr;
    logic [C*DW-1:0] core_wdata;
    logic [C-1:0]    wr, rr, ack, err;
    logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]   mem_addr;
    logic            mem_we, mem_re, mem_ready, busy;

    ram_arbiter #(.Cores(C), .AddrBits(AW), .DataBits(DW), .TimeoutBits(TB)) dut (
        .CLK(clk), .CPU_Reset_n(rst_n),
        .CORE_ADDR(core_addr), .CORE_WDATA(core_wdata), .CORE_WR(wr), .CORE_RR(rr),
        .CORE_RDATA(rdata), .CORE_ACK(ack), .CORE_ERR(err),
        .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata), .MEM_WE(mem_we), .MEM_RE(mem_re),
        .MEM_RDATA(mem_rdata), .MEM_READY(mem_ready), .BUSY(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, ready_pct = 50;
    // model: core in service (-1 none), access cycles elapsed, core being acknowledged (-1 none)
    int            m_core, m_age, m_ack, m_last;
    logic          m_w, m_r, m_err;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd, m_rd;
    logic [C-1:0]  m_rel;
    // core behaviour: 0 idle, 1 waiting for ACK, 2 holding request after ACK
    int            st[C], hold[C];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_core = -1; m_ack = -1; m_last = C - 1; m_age = 0;
        m_w = 0; m_r = 0; m_err = 0; m_rd = '0; m_rel = '0;
        m_addr = '0; m_wd = '0;
    endtask

    // advance the model across the next rising edge using the inputs the DUT will sample there
    task automatic model_edge();
        int i;
        if (m_ack >= 0) begin
            m_last = m_ack;
            m_rel[m_ack] = 1'b1;
            m_ack = -1;
        end else if (m_core >= 0) begin
            m_age++;
            if (mem_ready || m_age == TMO) begin
                m_err = !mem_ready;
                if (!mem_ready) m_rd = '0;
                else if (m_r) m_rd = mem_rdata;
                m_ack = m_core;
                m_core = -1;
            end
        end else begin
            for (int k = 1; k <= C; k++) begin
                i = (m_last + k) % C;
                if (m_core < 0 && (wr[i] || rr[i]) && !m_rel[i]) begin
                    m_core = i; m_age = 0;
                    m_w = wr[i]; m_r = rr[i] && !wr[i];
                    m_addr = core_addr[i*AW +: AW];
                    m_wd = core_wdata[i*DW +: DW];
                end
            end
        end
        for (int j = 0; j < C; j++)
            if (!wr[j] && !rr[j]) m_rel[j] = 1'b0;
    endtask

    task automatic compare();
        logic [C-1:0] eack;
        eack = (m_ack >= 0) ? C'(1) << m_ack : '0;
        check("busy", 32'(busy), 32'(m_core >= 0 || m_ack >= 0));
        check("mem_we", 32'(mem_we), 32'(m_core >= 0 && m_w));
        check("mem_re", 32'(mem_re), 32'(m_core >= 0 && m_r));
        check("core_ack", 32'(ack), 32'(eack));
        check("core_err", 32'(err), 32'(m_err ? eack : '0));
        check("core_rdata", 32'(rdata), 32'(m_rd));
        if (m_core >= 0) begin
            check("mem_addr", 32'(mem_addr), 32'(m_addr));
            check("mem_wdata", 32'(mem_wdata), 32'(m_wd));
        end
    endtask

    task automatic drive();
        int op;
        for (int i = 0; i < C; i++) begin
            if (m_ack == i) begin
                if ($urandom_range(1, 100) <= 50) begin
                    st[i] = 2; hold[i] = $urandom_range(1, 6);
                end else begin
                    st[i] = 0; wr[i] = 0; rr[i] = 0;
                end
            end else if (st[i] == 2) begin
                hold[i]--;
                if (hold[i] == 0) begin st[i] = 0; wr[i] = 0; rr[i] = 0; end
            end else if (st[i] == 0) begin
                if ($urandom_range(1, 100) <= 30) begin
                    op = $urandom_range(0, 2);
                    wr[i] = (op != 0); rr[i] = (op != 1); st[i] = 1;
                end
            end else if ($urandom_range(1, 100) <= 2) begin
                st[i] = 0; wr[i] = 0; rr[i] = 0;
            end
            core_addr[i*AW +: AW]  = AW'($urandom());
            core_wdata[i*DW +: DW] = DW'($urandom());
        end
        mem_ready = ($urandom_range(1, 100) <= ready_pct);
        mem_rdata = DW'($urandom());
    endtask

    task automatic step();
        @(negedge clk);
        compare();
        drive();
        model_edge();
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_we"}, 32'(mem_we), 0);
        check({tag, "_re"}, 32'(mem_re), 0);
        check({tag, "_ack"}, 32'(ack), 0);
        check({tag, "_err"}, 32'(err), 0);
        check({tag, "_rdata"}, 32'(rdata), 0);
        check({tag, "_addr"}, 32'(mem_addr), 0);
        check({tag, "_wdata"}, 32'(mem_wdata), 0);
    endtask

    initial begin
        bit hit;
        rst_n = 0; wr = '0; rr = '0; core_addr = '0; core_wdata = '0;
        mem_ready = 0; mem_rdata = '0;
        for (int i = 0; i < C; i++) begin st[i] = 0; hold[i] = 0; end
        repeat (3) @(negedge clk);
        check_quiet("reset");
        model_reset();
        rst_n = 1;
        model_edge();

        ready_pct = 70;  repeat (500) step();
        ready_pct = 4;   repeat (300) step();
        ready_pct = 100; repeat (200) step();

        ready_pct = 0; hit = 0;
        for (int n = 0; n < 200 && !hit; n++) begin
            step();
            hit = (m_core >= 0);
        end
        check("access_wait", 32'(hit), 1);
        @(posedge clk); #2;
        rst_n = 0; #1;
        check_quiet("midreset");
        model_reset();
        for (int i = 0; i < C; i++) begin st[i] = 0; wr[i] = 0; rr[i] = 0; end
        st[0] = 1; wr[0] = 1; st[1] = 1; rr[1] = 1;
        @(negedge clk);
        rst_n = 1;
        model_edge();
        @(posedge clk); #1;
        check("regrant_we", 32'(mem_we), 1);
        check("regrant_re", 32'(mem_re), 0);
        check("regrant_busy", 32'(busy), 1);

        ready_pct = 50; repeat (200) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
